serial_addsub: RTL and testbench
================================

Name: serial_addsub

Overview:
- Bit-serial add/subtract unit for the ALU datapath. Shifts two latched operands LSB-first through a single one-bit full-adder cell, one bit per clock, with the carry held in a flip-flop between bits.
- It is the sequential stage wrapped around the full-adder cell: it feeds the cell's a/b/c inputs and consumes its sum/carry outputs.
- It trades latency for area next to the ripple ALU, and reports the same flags: carryout, overflow and zero.

Parameters:
- WIDTH, 32: operand and result width in bits; legal range 2 or more.
- CNT_W, $clog2(WIDTH+1): width of the internal bit counter. Derived; do not override.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-high reset.
- start, input, 1: request a new operation; sampled only in IDLE or DONE.
- sub, input, 1: 0 = a+b, 1 = a-b; sampled with start.
- a, input, WIDTH: operand A; sampled with start.
- b, input, WIDTH: operand B; sampled with start.
- busy, output, 1: high while state is RUN.
- done, output, 1: one-cycle pulse when result and flags become valid.
- result, output, WIDTH: sum or difference; held until the next completion.
- carryout, output, 1: carry out of the MSB; held.
- overflow, output, 1: signed overflow; held.
- zero, output, 1: 1 when result is all zeros; held.

Behaviour:
- Reset (async, immediate): state=IDLE; counter, carry flop and shift registers cleared; busy=0, done=0, result=0, carryout=0, overflow=0, zero=0.
- A reset asserted mid-RUN aborts the operation. Outputs go to their reset values and there is no done pulse.
- States are IDLE, RUN and DONE, with encoding from the shared package.
- IDLE: start=1 at edge k moves to RUN. On that edge:
  - A goes into shift register sa.
  - B goes into sb, inverted bitwise when sub=1.
  - The carry flop gets sub, so subtraction is a + ~b + 1.
  - The counter is set to 0.
- RUN, each edge:
  - Cell inputs are sa[0], sb[0] and the carry flop.
  - The cell's sum bit shifts into the accumulator from the MSB side.
  - sa and sb shift right by one.
  - The cell's carry output loads the carry flop.
  - The counter increments.
- Last RUN edge (counter == WIDTH-1), in the same edge:
  - result loads the completed accumulator word.
  - carryout loads the final cell carry.
  - overflow loads (carry into MSB) XOR (carry out of MSB). The carry into the MSB is the carry flop value during the last bit.
  - zero loads (completed word == 0).
  - state moves to DONE.
- Latency: start sampled at edge k leaves result/flags valid and done=1 after edge k+WIDTH. done falls after edge k+WIDTH+1.
- DONE lasts exactly one cycle with done=1.
  - If start=0, go to IDLE.
  - If start=1, accept a new operation exactly as IDLE does, giving back-to-back throughput of one result per WIDTH+1 cycles.
- start during RUN is ignored: no restart, no queuing. Operands a, b and sub may change freely after the start edge.
- Outputs result, carryout, overflow and zero change only on a completion edge or on reset. The previous values stay stable through IDLE and the whole of RUN.
- Unsigned borrow: for sub=1, carryout=1 means a >= b (no borrow).
- The counter never exceeds WIDTH-1 in RUN. Wrap is prevented by the DONE transition.

Decomposition:
- Shared package (alu_pkg):
  - state enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Op code constants: OP_ADD=1'b0, OP_SUB=1'b1, matching the ALU op field for add/sub.
- One sub-module is natural: the team's existing one-bit full-adder cell (fulladder2), instantiated once as the datapath bit slice.
- The FSM, counter, shift registers and flag logic stay in serial_addsub.

Test Plan:
1. WIDTH=8: reset, then start with a=8'd5, b=8'd3, sub=0 -> busy high for 8 cycles; done pulses after edge k+8 with result=8'd8, carryout=0, overflow=0, zero=0.
2. WIDTH=8: a=8'h7F, b=8'h01, sub=0 -> result=8'h80, overflow=1, carryout=0. Then a=8'hFF, b=8'h01 -> result=8'h00, carryout=1, zero=1, overflow=0.
3. WIDTH=8: a=8'd3, b=8'd5, sub=1 -> result=8'hFE, carryout=0 (borrow). Then a=8'h80, b=8'h01, sub=1 -> result=8'h7F, overflow=1, carryout=1.
4. WIDTH=8: pulse start again at RUN cycle 3 with different operands -> ignored; the original result is delivered at the original time. Then hold start=1 in the DONE cycle -> next op accepted immediately and done recurs 9 cycles later.
5. WIDTH=32: a=32'hFFFF_FFFF, b=32'h0000_0001, sub=1 -> result=32'hFFFF_FFFE, carryout=1, done after exactly 32 RUN cycles. Randomized sweep of 1000 ops checked against a+b and a-b reference arithmetic.
6. WIDTH=8: assert reset asynchronously mid-RUN (cycle 4) -> busy, done and all outputs drop to 0 immediately with no done pulse. A fresh start after reset completes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared ALU definitions: sequencer state encoding for the
//                bit-serial add/subtract unit and the add/sub op codes that
//                match the ALU op field.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Sequencer states of the bit-serial add/subtract unit.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Op field values for add / subtract.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/fulladder2.sv
`default_nettype none
// ============================================================================
//  Module      : fulladder2
//  Description : One-bit full-adder cell, the datapath bit slice of the
//                serial add/subtract unit.
//  Ports       : a, b  - operand bits
//                c     - carry in
//                sum   - a ^ b ^ c
//                carry - majority(a, b, c)
//  Revision    : 1.0 - initial release
// ============================================================================
module fulladder2 (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule : fulladder2
`default_nettype wire

// File: rtl/serial_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : serial_addsub
//  Description : Bit-serial add/subtract unit. Operands are latched on start
//                and shifted LSB-first through one full-adder cell, one bit
//                per clock, with the carry held in a flop between bits.
//                Reports result, carryout, overflow and zero like the ripple
//                ALU. One result per WIDTH+1 cycles when started back-to-back.
//  Ports       : clk      - rising-edge clock
//                reset    - asynchronous, active-high reset
//                start    - new operation request (IDLE or DONE only)
//                sub      - 0: a+b, 1: a-b (sampled with start)
//                a, b     - operands (sampled with start)
//                busy     - high while an operation is in progress
//                done     - one-cycle pulse when result/flags are updated
//                result   - sum or difference, held until next completion
//                carryout - carry out of the MSB (for sub: 1 = no borrow)
//                overflow - signed overflow
//                zero     - result is all zeros
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;
  logic               w_last;
  logic               w_busy;
  logic               w_done;

  logic [WIDTH-1:0]   r_sa;
  logic [WIDTH-1:0]   r_sb;
  logic [WIDTH-1:0]   r_acc;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;

  logic [WIDTH-1:0]   r_result;
  logic               r_carryout;
  logic               r_overflow;
  logic               r_zero;

  logic               w_sum;
  logic               w_cout;
  logic [WIDTH-1:0]   w_acc_nxt;

  // --------------------------------------------------------------------------
  // Datapath bit slice
  // --------------------------------------------------------------------------
  fulladder2 u_cell (
    .a     (r_sa[0]),
    .b     (r_sb[0]),
    .c     (r_carry),
    .sum   (w_sum),
    .carry (w_cout)
  );

  // Sum bits enter from the MSB side so that after WIDTH shifts the first
  // (LSB) sum bit has arrived at bit 0.
  assign w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_busy = 1'b1;
        if (r_cnt == c_last_bit) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_done = 1'b1;
        // DONE accepts a new operation just like IDLE for back-to-back use.
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign busy = w_busy;
  assign done = w_done;

  // --------------------------------------------------------------------------
  // Operand shift registers, carry flop and bit counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sa    <= '0;
      r_sb    <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_sa    <= a;
      // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
      r_sb    <= (sub == OP_SUB) ? ~b : b;
      r_carry <= sub;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_acc   <= w_acc_nxt;
      r_sa    <= r_sa >> 1;
      r_sb    <= r_sb >> 1;
      r_carry <= w_cout;
      if (!w_last) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Result and flags: updated only on the final bit
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result   <= '0;
      r_carryout <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
    end else if (w_last) begin
      r_result   <= w_acc_nxt;
      r_carryout <= w_cout;
      // During the last bit the carry flop holds the carry into the MSB.
      r_overflow <= r_carry ^ w_cout;
      r_zero     <= (w_acc_nxt == '0);
    end
  end

  assign result   = r_result;
  assign carryout = r_carryout;
  assign overflow = r_overflow;
  assign zero     = r_zero;

endmodule : serial_addsub
`default_nettype wire

// File: tb/tb_serial_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_addsub
//  Description : Self-checking bench for serial_addsub with an 8-bit and a
//                32-bit instance. Expected results come from plain integer
//                arithmetic on the operands.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance
  logic        rst8, start8, sub8, busy8, done8, co8, ov8, z8;
  logic [7:0]  a8, b8, res8;
  // 32-bit instance
  logic        rst32, start32, sub32, busy32, done32, co32, ov32, z32;
  logic [31:0] a32, b32, res32;

  serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rst8), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(res8), .carryout(co8),
    .overflow(ov8), .zero(z8)
  );

  serial_addsub #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(rst32), .start(start32), .sub(sub32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .result(res32), .carryout(co32),
    .overflow(ov32), .zero(z32)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Selected instance view
  int          sel = 8;
  logic        o_busy, o_done, o_co, o_ov, o_z;
  logic [63:0] o_res;

  always_comb begin
    if (sel == 8) begin
      o_busy = busy8;  o_done = done8;  o_res = {56'd0, res8};
      o_co   = co8;    o_ov   = ov8;    o_z   = z8;
    end else begin
      o_busy = busy32; o_done = done32; o_res = {32'd0, res32};
      o_co   = co32;   o_ov   = ov32;   o_z   = z32;
    end
  end

  // Expected held outputs per instance (index 0: 8-bit, 1: 32-bit)
  logic [63:0] e_res [2];
  logic        e_co  [2];
  logic        e_ov  [2];
  logic        e_z   [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: plain unsigned/signed arithmetic on w-bit values.
  task automatic ref_model(input int w, input logic [63:0] a, input logic [63:0] b,
                           input logic s, output logic [63:0] r,
                           output logic co, output logic ov);
    logic [63:0] mask;
    logic [63:0] full;
    mask = (64'd1 << w) - 64'd1;
    if (!s) begin
      full = (a & mask) + (b & mask);
      r    = full & mask;
      co   = full[w];
      ov   = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]);
    end else begin
      r  = ((a & mask) - (b & mask)) & mask;
      co = ((a & mask) >= (b & mask));
      ov = (a[w-1] != b[w-1]) && (r[w-1] != a[w-1]);
    end
  endtask

  function automatic logic [63:0] rnd_op(input int w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return mask;
      2:       return 64'd1 << (w - 1);
      3:       return mask >> 1;
      default: return {$urandom, $urandom} & mask;
    endcase
  endfunction

  task automatic drv(input int w, input logic st, input logic [63:0] a,
                     input logic [63:0] b, input logic s);
    if (w == 8) begin
      start8 = st; a8 = a[7:0]; b8 = b[7:0]; sub8 = s;
    end else begin
      start32 = st; a32 = a[31:0]; b32 = b[31:0]; sub32 = s;
    end
  endtask

  task automatic check_held(input string tag, input int wi);
    chk({tag, "_result"},   o_res, e_res[wi]);
    chk({tag, "_carryout"}, o_co,  e_co[wi]);
    chk({tag, "_overflow"}, o_ov,  e_ov[wi]);
    chk({tag, "_zero"},     o_z,   e_z[wi]);
  endtask

  // Called with the clock low. Leaves at the negedge of the DONE cycle.
  // glitch > 0 pulses start (with other operands) in that RUN cycle.
  task automatic do_op(input int w, input logic [63:0] a, input logic [63:0] b,
                       input logic s, input int glitch);
    int          wi;
    logic [63:0] r;
    logic        co, ov;
    wi  = (w == 8) ? 0 : 1;
    sel = w;
    ref_model(w, a, b, s, r, co, ov);
    drv(w, 1'b1, a, b, s);
    @(posedge clk);
    @(negedge clk);
    drv(w, 1'b0, rnd_op(w), rnd_op(w), 1'($urandom_range(0, 1)));
    chk("run_busy", o_busy, 1);
    chk("run_done", o_done, 0);
    for (int i = 1; i <= w; i++) begin
      drv(w, (i == glitch), rnd_op(w), rnd_op(w), 1'($urandom_range(0, 1)));
      @(posedge clk);
      @(negedge clk);
      if (i < w) begin
        chk("run_busy", o_busy, 1);
        chk("run_done", o_done, 0);
        check_held("run_hold", wi);
      end else begin
        chk("cpl_done", o_done, 1);
        chk("cpl_busy", o_busy, 0);
        e_res[wi] = r;
        e_co[wi]  = co;
        e_ov[wi]  = ov;
        e_z[wi]   = (r == 64'd0);
        check_held("cpl", wi);
      end
    end
    drv(w, 1'b0, 64'd0, 64'd0, 1'b0);
  endtask

  task automatic idle(input int w);
    sel = w;
    drv(w, 1'b0, 64'd0, 64'd0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("idle_done", o_done, 0);
    chk("idle_busy", o_busy, 0);
    check_held("idle_hold", (w == 8) ? 0 : 1);
  endtask

  initial begin
    rst8 = 1'b1; rst32 = 1'b1;
    drv(8, 1'b0, 64'd0, 64'd0, 1'b0);
    drv(32, 1'b0, 64'd0, 64'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      e_res[i] = 64'd0; e_co[i] = 1'b0; e_ov[i] = 1'b0; e_z[i] = 1'b0;
    end
    #12;
    sel = 8;  #1;
    chk("rst8_busy", o_busy, 0); chk("rst8_done", o_done, 0); check_held("rst8", 0);
    sel = 32; #1;
    chk("rst32_busy", o_busy, 0); chk("rst32_done", o_done, 0); check_held("rst32", 1);
    @(negedge clk);
    rst8 = 1'b0; rst32 = 1'b0;
    @(negedge clk);

    // Directed 8-bit cases
    do_op(8, 64'd5,    64'd3,    1'b0, 0); idle(8);
    do_op(8, 64'h7F,   64'h01,   1'b0, 0); idle(8);
    do_op(8, 64'hFF,   64'h01,   1'b0, 0); idle(8);
    do_op(8, 64'd3,    64'd5,    1'b1, 0); idle(8);
    do_op(8, 64'h80,   64'h01,   1'b1, 0); idle(8);

    // Start during RUN ignored; then start held in DONE chains immediately
    do_op(8, 64'h12,   64'h34,   1'b0, 3);
    do_op(8, 64'h40,   64'h40,   1'b1, 0);
    idle(8);

    // Asynchronous reset in the middle of RUN
    sel = 8;
    drv(8, 1'b1, 64'hA5, 64'h11, 1'b0);
    @(posedge clk);
    drv(8, 1'b0, 64'd0, 64'd0, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst8 = 1'b1;
    #1;
    e_res[0] = 64'd0; e_co[0] = 1'b0; e_ov[0] = 1'b0; e_z[0] = 1'b0;
    chk("arst_busy", o_busy, 0);
    chk("arst_done", o_done, 0);
    check_held("arst", 0);
    @(negedge clk);
    rst8 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("arst_nodone", o_done, 0);
      chk("arst_nobusy", o_busy, 0);
    end
    do_op(8, 64'h0F, 64'hF1, 1'b0, 0); idle(8);

    // Random 8-bit ops, chained or with idle gaps
    for (int n = 0; n < 200; n++) begin
      do_op(8, rnd_op(8), rnd_op(8), 1'($urandom_range(0, 1)), 0);
      if ($urandom_range(0, 3) != 0) idle(8);
    end
    idle(8);

    // 32-bit directed and random sweep
    do_op(32, 64'hFFFF_FFFF, 64'h0000_0001, 1'b1, 0); idle(32);
    for (int n = 0; n < 1000; n++) begin
      do_op(32, rnd_op(32), rnd_op(32), 1'($urandom_range(0, 1)), 0);
      if ($urandom_range(0, 3) != 0) idle(32);
    end
    idle(32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_serial_addsub
`default_nettype wire
